drops_input_conditioner: RTL and testbench

Front-end input stage for the drops game core. It takes the raw asynchronous up/down push-buttons from the dedicated input pins and synchronises and debounces them. It converts them into clean single-cycle move strobes with hold-to-autorepeat, which the game logic consumes directly. All state is per-button, except a final mutual-exclusion stage that resolves up/down conflicts.

---
 rtl/drops_input_conditioner_pkg.sv | 21 ++
 rtl/drops_input_conditioner_if.sv | 20 ++
 rtl/drops_input_conditioner_btn_channel.sv | 111 +++++++++++
 rtl/drops_input_conditioner.sv | 60 ++++++
 tb/tb_drops_input_conditioner.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/drops_input_conditioner_pkg.sv
// Shared constants for the drops input front end: button indices, FSM
// encodings, default timing and a counter-width helper.
package drops_input_conditioner_pkg;

    localparam int BTN_UP   = 0;
    localparam int BTN_DOWN = 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int DEF_DEBOUNCE_CYCLES = 20000;
    localparam int DEF_REPEAT_DELAY    = 300000;
    localparam int DEF_REPEAT_RATE     = 100000;

    // Counter width for a terminal count of (v-1); never narrower than 1 bit.
    function automatic int cnt_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/drops_input_conditioner_if.sv
// Button input / move strobe bundle between the pins side and the game core.
interface drops_input_conditioner_if;
    logic       ena;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic       move_up;
    logic       move_down;

    modport master (
        output ena, btn_raw,
        input  btn_level, btn_press, btn_release, move_up, move_down
    );

    modport slave (
        input  ena, btn_raw,
        output btn_level, btn_press, btn_release, move_up, move_down
    );
endinterface

// File: rtl/drops_input_conditioner_btn_channel.sv
// One button channel: 2-FF synchroniser, debounce and press/repeat FSM.
// Outputs are the next-cycle values; the top level registers them so that
// the conflict gating sees the post-update levels in the same cycle.
module drops_btn_channel
    import drops_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic btn_raw,
    output logic level_next,
    output logic press_next,
    output logic release_next,
    output logic repeat_next
);
    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(REPEAT_DELAY);
    localparam int RW = cnt_width(REPEAT_RATE);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

    logic [1:0]    sync_reg;
    logic          level_reg;
    logic [DW-1:0] db_cnt_reg, db_cnt_next;
    logic [1:0]    state_reg, state_next;
    logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
    logic [RW-1:0] rate_cnt_reg, rate_cnt_next;
    logic          rise, fall;

    // Synchroniser: cleared only by rst_n so ena never loses the pin state.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_reg <= '0;
        else        sync_reg <= {sync_reg[0], btn_raw};
    end

    // Debounce: count consecutive disagreeing cycles, flip level on the last.
    always_comb begin
        db_cnt_next = '0;
        level_next  = level_reg;
        if (sync_reg[1] != level_reg) begin
            if (db_cnt_reg == DB_LAST) level_next  = ~level_reg;
            else                       db_cnt_next = db_cnt_reg + 1'b1;
        end
    end

    assign rise = level_next & ~level_reg;
    assign fall = ~level_next & level_reg;

    // Press/hold/repeat FSM; a falling edge always wins over a repeat.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        rate_cnt_next = rate_cnt_reg;
        repeat_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (rise) begin
                    state_next    = ST_HELD;
                    hold_cnt_next = '0;
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end else if (hold_cnt_reg == HOLD_LAST) begin
                    repeat_next   = 1'b1;
                    rate_cnt_next = '0;
                    state_next    = ST_REPEAT;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (fall) begin
                    state_next = ST_IDLE;
                end else if (rate_cnt_reg == RATE_LAST) begin
                    repeat_next   = 1'b1;
                    rate_cnt_next = '0;
                end else begin
                    rate_cnt_next = rate_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign press_next   = rise;
    assign release_next = fall;

    // Channel state: cleared by reset or by ena low.
    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            level_reg    <= 1'b0;
            db_cnt_reg   <= '0;
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            rate_cnt_reg <= '0;
        end else begin
            level_reg    <= level_next;
            db_cnt_reg   <= db_cnt_next;
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            rate_cnt_reg <= rate_cnt_next;
        end
    end
endmodule

// File: rtl/drops_input_conditioner.sv
// Top of the input front end: two button channels plus registered
// up/down conflict gating. Every output comes straight from a flop.
module drops_input_conditioner
    import drops_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    drops_input_conditioner_if.slave   bus
);
    logic [1:0] level_next, press_next, release_next, repeat_next;
    logic [1:0] level_reg, press_reg, release_reg;
    logic       move_up_reg, move_down_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            drops_btn_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE)
            ) u_ch (
                .clk          (clk),
                .rst_n        (rst_n),
                .ena          (bus.ena),
                .btn_raw      (bus.btn_raw[gi]),
                .level_next   (level_next[gi]),
                .press_next   (press_next[gi]),
                .release_next (release_next[gi]),
                .repeat_next  (repeat_next[gi])
            );
        end
    endgenerate

    // Output registers; a move is suppressed while the opposite button is down.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.ena) begin
            level_reg     <= '0;
            press_reg     <= '0;
            release_reg   <= '0;
            move_up_reg   <= 1'b0;
            move_down_reg <= 1'b0;
        end else begin
            level_reg     <= level_next;
            press_reg     <= press_next;
            release_reg   <= release_next;
            move_up_reg   <= (press_next[BTN_UP] | repeat_next[BTN_UP]) & ~level_next[BTN_DOWN];
            move_down_reg <= (press_next[BTN_DOWN] | repeat_next[BTN_DOWN]) & ~level_next[BTN_UP];
        end
    end

    assign bus.btn_level   = level_reg;
    assign bus.btn_press   = press_reg;
    assign bus.btn_release = release_reg;
    assign bus.move_up     = move_up_reg;
    assign bus.move_down   = move_down_reg;
endmodule

// File: tb/tb_drops_input_conditioner.sv
// Bench for drops_input_conditioner: directed scenarios followed by random
// button activity, checked cycle by cycle against a window-based model.
module tb_drops_input_conditioner;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RR = 8;

    logic clk = 1'b0;
    logic rst_n;
    drops_input_conditioner_if bus();

    drops_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard: {level[1:0], press[1:0], release[1:0], move_up, move_down}
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int exp_up = 0, exp_dn = 0, act_up = 0, act_dn = 0;
    int mon_cyc = 0;

    // Reference model state
    logic [1:0]  m_s1 = '0, m_s2 = '0, m_lvl = '0;
    logic [15:0] m_hb[2];
    int          m_hn[2];
    int          m_p[2];
    int          t = 0;

    function automatic void clear_model();
        m_lvl = '0;
        for (int b = 0; b < 2; b++) begin
            m_hb[b] = '0;
            m_hn[b] = 0;
            m_p[b]  = 0;
        end
    endfunction

    // Level flips once the last D synchronised samples all disagree with it.
    // Repeats fall at press+RD, then every RR cycles while held.
    function automatic void model_edge(input logic [1:0] raw, input logic rn, input logic en);
        logic [1:0] old_s2, pr, rl, rp;
        logic mu, md, mism;
        int d;
        pr = '0; rl = '0; rp = '0; mu = 1'b0; md = 1'b0;
        t++;
        if (!rn) begin
            m_s1 = '0;
            m_s2 = '0;
            clear_model();
        end else begin
            old_s2 = m_s2;
            m_s2   = m_s1;
            m_s1   = raw;
            if (!en) begin
                clear_model();
            end else begin
                for (int b = 0; b < 2; b++) begin
                    m_hb[b] = {m_hb[b][14:0], old_s2[b]};
                    if (m_hn[b] < D) m_hn[b]++;
                    mism = (m_hn[b] == D);
                    for (int i = 0; i < D; i++)
                        if (m_hb[b][i] == m_lvl[b]) mism = 1'b0;
                    if (mism) begin
                        m_lvl[b] = ~m_lvl[b];
                        m_hn[b]  = 0;
                        pr[b]    = m_lvl[b];
                        rl[b]    = ~m_lvl[b];
                        if (m_lvl[b]) m_p[b] = t;
                    end else if (m_lvl[b]) begin
                        d = t - m_p[b];
                        if (d >= RD && ((d - RD) % RR) == 0) rp[b] = 1'b1;
                    end
                end
                mu = (pr[0] | rp[0]) & ~m_lvl[1];
                md = (pr[1] | rp[1]) & ~m_lvl[0];
            end
        end
        if (mu) exp_up++;
        if (md) exp_dn++;
        exp_q.push_back({m_lvl, pr, rl, mu, md});
    endfunction

    // Monitor: compares the DUT outputs each cycle against the oldest expectation.
    always @(negedge clk) begin
        logic [7:0] e, a;
        if (exp_q.size() > 0) begin
            mon_cyc++;
            e = exp_q.pop_front();
            a = {bus.btn_level, bus.btn_press, bus.btn_release, bus.move_up, bus.move_down};
            if (a[1]) act_up++;
            if (a[0]) act_dn++;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: got lvl=%b prs=%b rel=%b up=%b dn=%b, expected lvl=%b prs=%b rel=%b up=%b dn=%b",
                         mon_cyc, a[7:6], a[5:4], a[3:2], a[1], a[0], e[7:6], e[5:4], e[3:2], e[1], e[0]);
            end
        end
    end

    task automatic step(input logic [1:0] raw, input logic rn, input logic en);
        bus.btn_raw = raw;
        rst_n       = rn;
        bus.ena     = en;
        @(posedge clk);
        model_edge(raw, rn, en);
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] raw, input int n);
        repeat (n) step(raw, 1'b1, 1'b1);
    endtask

    initial begin
        int dur[2];
        logic [1:0] raw;
        logic rn, en;
        int en_low;
        clear_model();

        // Reset
        repeat (3) step(2'b00, 1'b0, 1'b1);
        hold(2'b00, 6);
        // Clean press with autorepeat, then release
        hold(2'b01, 90);
        hold(2'b00, 10);
        // Bounce on down: 1, 2 and 3 cycle pulses
        hold(2'b10, 1); hold(2'b00, 1);
        hold(2'b10, 2); hold(2'b00, 1);
        hold(2'b10, 3); hold(2'b00, 10);
        // Conflict: both pressed together, then release down
        hold(2'b11, 30);
        hold(2'b01, 40);
        hold(2'b00, 15);
        // Reset while up is repeating, button kept held
        hold(2'b01, 40);
        step(2'b01, 1'b0, 1'b1);
        hold(2'b01, 30);
        hold(2'b00, 12);
        // ena low while held
        hold(2'b01, 30);
        step(2'b01, 1'b1, 1'b0);
        hold(2'b01, 20);
        hold(2'b00, 12);

        // Random activity
        raw = 2'b00;
        dur[0] = 0;
        dur[1] = 0;
        en_low = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 2; b++) begin
                if (dur[b] == 0) begin
                    raw[b] = ~raw[b];
                    dur[b] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(5, 70));
                end
                dur[b]--;
            end
            rn = ($urandom_range(0, 499) != 0);
            if (en_low == 0 && $urandom_range(0, 399) == 0) en_low = $urandom_range(1, 3);
            en = (en_low == 0);
            if (en_low > 0) en_low--;
            step(raw, rn, en);
        end
        hold(2'b00, 10);
        @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        checks++;
        if (act_up != exp_up) begin
            errors++;
            $display("FAIL move_up_count: got %0d, expected %0d", act_up, exp_up);
        end
        checks++;
        if (act_dn != exp_dn) begin
            errors++;
            $display("FAIL move_down_count: got %0d, expected %0d", act_dn, exp_dn);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
